// File: rtl/mux_arbiter_pkg.sv
// Shared types and size derivation for the round-robin mux arbiter.
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFull,
        StLock
    } state_e;

    function automatic int unsigned nb_in(input int unsigned size_ctrl);
        return 32'd1 << size_ctrl;
    endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// Pure data selector: picks one WIRE-bit lane out of NB_IN packed lanes.
module mux
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned SIZE_CTRL = 2,
    parameter int unsigned WIRE      = 8,
    localparam int unsigned NB_IN    = nb_in(SIZE_CTRL)
) (
    input  logic [SIZE_CTRL-1:0]  sel,
    input  logic [NB_IN*WIRE-1:0] in_data,
    output logic [WIRE-1:0]       out_data
);

    assign out_data = in_data[sel*WIRE +: WIRE];

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin N:1 arbiter with a one-deep registered output slot.
// Define MUX_ARBITER_LOCK_EN to hold the grant for a packet until its last beat.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned SIZE_CTRL = 2,
    parameter int unsigned WIRE      = 8,
    localparam int unsigned NB_IN    = nb_in(SIZE_CTRL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NB_IN-1:0]      in_valid,
    output logic [NB_IN-1:0]      in_ready,
    input  logic [NB_IN*WIRE-1:0] in_data,
    input  logic [NB_IN-1:0]      in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIRE-1:0]       out_data,
    output logic [SIZE_CTRL-1:0]  out_src,
    output logic                  out_last
);

`ifdef MUX_ARBITER_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    state_e               state_q, state_d;
    logic [SIZE_CTRL-1:0] ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIRE-1:0]      out_data_q, out_data_d;
    logic [SIZE_CTRL-1:0] out_src_q, out_src_d;
    logic                 out_last_q, out_last_d;

    logic [SIZE_CTRL-1:0] grant_idx;
    logic [SIZE_CTRL-1:0] cand;
    logic                 grant_found;
    logic                 slot_free;
    logic                 xfer;
    logic [WIRE-1:0]      sel_data;

    mux #(
        .SIZE_CTRL (SIZE_CTRL),
        .WIRE      (WIRE)
    ) u_mux (
        .sel      (grant_idx),
        .in_data  (in_data),
        .out_data (sel_data)
    );

    // Locked: only the owner (ptr_q) may go; otherwise scan ptr+1 .. ptr, ptr itself last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        cand        = ptr_q;
        if (state_q == StLock) begin
            grant_found = in_valid[ptr_q];
        end else begin
            for (int unsigned k = 1; k <= NB_IN; k++) begin
                cand = ptr_q + SIZE_CTRL'(k);
                if (!grant_found && in_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign xfer      = grant_found && slot_free && rst_n;
    assign in_ready  = xfer ? (NB_IN'(1) << grant_idx) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = grant_idx;
            out_last_d  = in_last[grant_idx];
            ptr_d       = grant_idx;
            state_d     = (LockEn && !in_last[grant_idx]) ? StLock : StFull;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            // An open packet keeps its lock even while the slot sits empty.
            if (state_q != StLock) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= SIZE_CTRL'(NB_IN - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_mux_arbiter;

    localparam int N = 4;
    localparam int W = 8;

`ifdef MUX_ARBITER_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_last;

    int checks = 0;
    int errors = 0;

    mux_arbiter #(
        .SIZE_CTRL (2),
        .WIRE      (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an output slot, a last-winner index and a packet-ownership flag.
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [1:0]   m_src;
    logic         m_last;
    int           m_ptr;
    logic         m_lock;

    function automatic int exp_grant();
        int g;
        g = -1;
        if (!rst_n || (m_valid && !out_ready)) return -1;
        if (m_lock) begin
            if (in_valid[m_ptr]) g = m_ptr;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && in_valid[idx]) g = idx;
            end
        end
        return g;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= '0;
            m_last  <= 1'b0;
            m_ptr   <= N - 1;
            m_lock  <= 1'b0;
        end else if (exp_grant() >= 0) begin
            m_valid <= 1'b1;
            m_data  <= in_data[exp_grant()*W +: W];
            m_src   <= 2'(exp_grant());
            m_last  <= in_last[exp_grant()];
            m_ptr   <= exp_grant();
            m_lock  <= LOCK && !in_last[exp_grant()];
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_last   = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 0000", in_ready);
        end
        checks++;
        if (out_data !== 8'h00 || out_src !== 2'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h src=%0d last=%b want 00/0/0",
                     out_data, out_src, out_last);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant got %b want 0001", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL reset_first_beat got v=%b src=%0d data=%h want 1/0/a0",
                     out_valid, out_src, out_data);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_valid  = 4'b1111;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(i % 4) || out_data !== 8'(8'hA0 + i % 4)) begin
                errors++;
                $display("FAIL rr_beat%0d got v=%b src=%0d data=%h want 1/%0d/%h",
                         i, out_valid, out_src, out_data, i % 4, 8'hA0 + i % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid      = 4'b0001;
        in_data[7:0]  = 8'h55;
        out_ready     = 1'b0;
        tick();
        in_valid      = 4'b0010;
        in_data[15:8] = 8'hB1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready%0d got %b want 0000", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h55 || out_src !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b data=%h src=%0d want 1/55/0",
                         i, out_valid, out_data, out_src);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ready got %b want 0010", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hB1 || out_src !== 2'd1) begin
            errors++;
            $display("FAIL bp_refill got v=%b data=%h src=%0d want 1/b1/1",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data[23:16] = 8'(8'h20 + i);
            #1;
            checks++;
            if (in_ready !== 4'b0100) begin
                errors++;
                $display("FAIL sparse_ready%0d got %b want 0100", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 8'(8'h20 + i)) begin
                errors++;
                $display("FAIL sparse_beat%0d got v=%b src=%0d data=%h want 1/2/%h",
                         i, out_valid, out_src, out_data, 8'h20 + i);
            end
        end
    endtask

    task automatic test_lock();
        int exp_src[4];
        int beats1;
        if (LOCK) exp_src = '{1, 1, 1, 3};
        else      exp_src = '{1, 3, 1, 3};
        do_reset();
        in_valid  = 4'b1010;
        in_data   = {8'hC3, 8'h00, 8'hC1, 8'h00};
        out_ready = 1'b1;
        beats1    = 0;
        for (int i = 0; i < 4; i++) begin
            in_last = {1'b1, 1'b0, (beats1 == 2), 1'b0};
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(exp_src[i])) begin
                errors++;
                $display("FAIL lock_beat%0d got v=%b src=%0d want 1/%0d",
                         i, out_valid, out_src, exp_src[i]);
            end
            if (exp_src[i] == 1) beats1++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            in_data   = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            in_last   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== exp_ready()) begin
                errors++;
                $display("FAIL rand_ready%0d got %b want %b", i, in_ready, exp_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_src !== m_src
                || out_last !== m_last) begin
                errors++;
                $display("FAIL rand_out%0d got v=%b d=%h s=%0d l=%b want %b/%h/%0d/%b",
                         i, out_valid, out_data, out_src, out_last,
                         m_valid, m_data, m_src, m_last);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
